// File: rtl/cache_line_fill_buffer.sv
// Line fill buffer: assembles a 128-word cache line from wrap-around refill beats (critical word first).
// Optional critical-word bypass outputs are enabled with CACHE_LINE_FILL_CRIT_BYPASS_EN.
module cache_line_fill_buffer #(
    parameter int w = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill_req,
    input  logic [6:0]       fill_offset,
    output logic             fill_ready,
    input  logic             mem_valid,
    input  logic [w-1:0]     mem_data,
    output logic             mem_ready,
    output logic [w*128-1:0] line_data,
    output logic             line_valid,
    input  logic             line_ack,
    output logic             busy,
    output logic [7:0]       beat_cnt
`ifdef CACHE_LINE_FILL_CRIT_BYPASS_EN
    ,
    output logic             crit_valid,
    output logic [w-1:0]     crit_data
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    beat_s;
    logic                    accept_s;
    logic [6:0]              ptr_r;
    logic [7:0]              beat_cnt_r;
    logic [127:0][w-1:0]     line_r;

    // Next-state decode; the 128th accepted beat closes the fill.
    always_comb begin
        state_s  = state_r;
        beat_s   = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (fill_req) begin
                    accept_s = 1'b1;
                    state_s  = FILL;
                end else begin
                    state_s  = IDLE;
                end
            end
            FILL: begin
                beat_s = mem_valid;
                if (mem_valid && (beat_cnt_r == 8'd127)) begin
                    state_s = DONE;
                end else begin
                    state_s = FILL;
                end
            end
            DONE: begin
                if (line_ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, write pointer and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ptr_r      <= 7'd0;
            beat_cnt_r <= 8'd0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                ptr_r      <= fill_offset;
                beat_cnt_r <= 8'd0;
            end else if (beat_s) begin
                ptr_r      <= ptr_r + 7'd1;
                beat_cnt_r <= beat_cnt_r + 8'd1;
            end else begin
                ptr_r      <= ptr_r;
                beat_cnt_r <= beat_cnt_r;
            end
        end
    end

    // Line storage: only the slot under the pointer changes on a beat (pointer wraps naturally at 7 bits).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r <= '0;
        end else if (beat_s) begin
            line_r[ptr_r] <= mem_data;
        end else begin
            line_r <= line_r;
        end
    end

    assign fill_ready = (state_r == IDLE);
    assign mem_ready  = (state_r == FILL);
    assign line_valid = (state_r == DONE);
    assign busy       = (state_r != IDLE);
    assign beat_cnt   = beat_cnt_r;
    assign line_data  = line_r;

`ifdef CACHE_LINE_FILL_CRIT_BYPASS_EN
    logic             crit_valid_r;
    logic [w-1:0]     crit_data_r;

    // Capture the first beat of each fill and pulse its valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crit_valid_r <= 1'b0;
            crit_data_r  <= '0;
        end else begin
            crit_valid_r <= beat_s && (beat_cnt_r == 8'd0);
            if (beat_s && (beat_cnt_r == 8'd0)) begin
                crit_data_r <= mem_data;
            end else begin
                crit_data_r <= crit_data_r;
            end
        end
    end

    assign crit_valid = crit_valid_r;
    assign crit_data  = crit_data_r;
`endif

endmodule

// File: tb/tb_cache_line_fill_buffer.sv
// Randomized self-checking bench for cache_line_fill_buffer against a slot-arithmetic line model.
module tb_cache_line_fill_buffer;
    localparam int W = 8;

    logic             clk;
    logic             rst_n;
    logic             fill_req;
    logic [6:0]       fill_offset;
    logic             fill_ready;
    logic             mem_valid;
    logic [W-1:0]     mem_data;
    logic             mem_ready;
    logic [W*128-1:0] line_data;
    logic             line_valid;
    logic             line_ack;
    logic             busy;
    logic [7:0]       beat_cnt;
`ifdef CACHE_LINE_FILL_CRIT_BYPASS_EN
    logic             crit_valid;
    logic [W-1:0]     crit_data;
`endif

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    cache_line_fill_buffer #(.w(W)) dut (
        .clk(clk), .rst_n(rst_n), .fill_req(fill_req), .fill_offset(fill_offset),
        .fill_ready(fill_ready), .mem_valid(mem_valid), .mem_data(mem_data),
        .mem_ready(mem_ready), .line_data(line_data), .line_valid(line_valid),
        .line_ack(line_ack), .busy(busy), .beat_cnt(beat_cnt)
`ifdef CACHE_LINE_FILL_CRIT_BYPASS_EN
        , .crit_valid(crit_valid), .crit_data(crit_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a fill is "busy" from acceptance until ack; beat k lands in slot (offset+k) mod 128.
    logic         m_busy, m_done, m_cv;
    int           m_off, m_count;
    logic [W-1:0] m_line [128];
    logic [W-1:0] m_cd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_off <= 0; m_count <= 0;
            m_cv <= 1'b0; m_cd <= '0;
            for (int i = 0; i < 128; i++) m_line[i] <= '0;
        end else begin
            m_cv <= 1'b0;
            if (!m_busy) begin
                if (fill_req) begin
                    m_busy <= 1'b1; m_off <= int'(fill_offset); m_count <= 0;
                end
            end else if (!m_done) begin
                if (mem_valid) begin
                    m_line[(m_off + m_count) % 128] <= mem_data;
                    m_count <= m_count + 1;
                    if (m_count == 127) m_done <= 1'b1;
                    if (m_count == 0) begin
                        m_cv <= 1'b1; m_cd <= mem_data;
                    end
                end
            end else if (line_ack) begin
                m_busy <= 1'b0; m_done <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the reference.
    always @(posedge clk) begin
        #1;
        if (checking) begin
            int bad;
            chk("fill_ready", 32'(fill_ready), 32'(!m_busy));
            chk("mem_ready", 32'(mem_ready), 32'(m_busy && !m_done));
            chk("line_valid", 32'(line_valid), 32'(m_done));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("beat_cnt", 32'(beat_cnt), 32'(m_count));
`ifdef CACHE_LINE_FILL_CRIT_BYPASS_EN
            chk("crit_valid", 32'(crit_valid), 32'(m_cv));
            chk("crit_data", 32'(crit_data), 32'(m_cd));
`endif
            bad = -1;
            for (int i = 127; i >= 0; i--)
                if (line_data[i*W +: W] !== m_line[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL line_word[%0d]: got %0h expected %0h at %0t",
                         bad, line_data[bad*W +: W], m_line[bad], $time);
            end
        end
    end

    // kind: 0 data=j, 1 data=A0+j, 2 random, 3 first beat 3C then random.
    // stall: 0 back-to-back, 1 alternate starting idle, 2 random.
    task automatic run_fill(input int off, input int kind, input int stall,
                            input int ack_dly, input bit hold_req, input int stop_after);
        logic [W-1:0] d [128];
        int j, guard, fill_cyc, rdy_cyc;
        for (int i = 0; i < 128; i++) begin
            case (kind)
                0: d[i] = W'(i);
                1: d[i] = W'(8'hA0 + i);
                default: d[i] = W'($urandom);
            endcase
        end
        if (kind == 3) d[0] = 8'h3C;
        guard = 0;
        while (m_busy && guard < 1000) begin
            @(negedge clk); guard++;
        end
        if (m_busy) chk("idle_timeout", 32'd1, 32'd0);
        fill_req = 1'b1; fill_offset = 7'(off);
        @(negedge clk);
        fill_req = hold_req;
        j = 0; guard = 0; fill_cyc = 0; rdy_cyc = 0;
        while (j < stop_after && guard < 2000) begin
            if (stall == 0) mem_valid = 1'b1;
            else if (stall == 1) mem_valid = (fill_cyc % 2 == 1);
            else mem_valid = 1'($urandom_range(0, 1));
            mem_data = d[j];
            line_ack = 1'($urandom_range(0, 1));
            if (stall == 0 && j == 127 && stop_after == 128) chk("pre_done_valid", 32'(line_valid), 32'd0);
            if (mem_ready) rdy_cyc++;
            @(negedge clk);
            if (mem_valid) j++;
            fill_cyc++; guard++;
        end
        mem_valid = 1'b0; line_ack = 1'b0;
        if (j < stop_after) chk("beat_timeout", 32'(j), 32'(stop_after));
        if (stop_after == 128) begin
            chk("done_valid", 32'(line_valid), 32'd1);
            chk("done_beat_cnt", 32'(beat_cnt), 32'd128);
            if (stall == 1) chk("stall_fill_cycles", 32'(rdy_cyc), 32'd256);
            for (int k = 0; k < ack_dly; k++) @(negedge clk);
            chk("done_held", 32'(line_valid), 32'd1);
            fill_req = 1'b0; line_ack = 1'b1;
            @(negedge clk);
            line_ack = 1'b0;
            chk("ack_idle", 32'(fill_ready), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0; fill_req = 1'b0; fill_offset = 7'd0;
        mem_valid = 1'b0; mem_data = '0; line_ack = 1'b0;
        repeat (3) @(negedge clk);
        checking = 1;
        chk("rst_fill_ready", 32'(fill_ready), 32'd1);
        chk("rst_line_valid", 32'(line_valid), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_line_zero", 32'(line_data == '0), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Linear fill
        run_fill(0, 0, 0, 2, 1'b0, 128);
        for (int i = 0; i < 128; i += 37) chk("lin_word", 32'(line_data[i*W +: W]), 32'(i));
        chk("lin_word127", 32'(line_data[127*W +: W]), 32'd127);

        // Wrap fill with fill_req held through DONE
        run_fill(120, 1, 0, 5, 1'b1, 128);
        chk("wrap_w120", 32'(line_data[120*W +: W]), 32'hA0);
        chk("wrap_w127", 32'(line_data[127*W +: W]), 32'hA7);
        chk("wrap_w0", 32'(line_data[0 +: W]), 32'hA8);
        chk("wrap_w119", 32'(line_data[119*W +: W]), 32'h1F);

        // Alternating stalls, offset 127
        run_fill(127, 0, 1, 1, 1'b0, 128);
        chk("stall_w127", 32'(line_data[127*W +: W]), 32'd0);
        chk("stall_w0", 32'(line_data[0 +: W]), 32'd1);
        chk("stall_w126", 32'(line_data[126*W +: W]), 32'd127);

        // Mid-fill reset after 50 beats, fill_req held
        run_fill(33, 2, 0, 0, 1'b1, 50);
        rst_n = 1'b0; fill_req = 1'b0;
        #1;
        chk("mrst_fill_ready", 32'(fill_ready), 32'd1);
        chk("mrst_mem_ready", 32'(mem_ready), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("mrst_line_zero", 32'(line_data == '0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef CACHE_LINE_FILL_CRIT_BYPASS_EN
        run_fill(5, 3, 0, 3, 1'b0, 128);
        chk("crit_data_held", 32'(crit_data), 32'h3C);
        chk("crit_w5", 32'(line_data[5*W +: W]), 32'h3C);
`endif

        // Randomized fills
        for (int n = 0; n < 6; n++)
            run_fill(int'($urandom_range(0, 127)), 2, 2, int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)), 128);

        repeat (2) @(negedge clk);
        checking = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
